run_length_detector: RTL and testbench
======================================

// Module: run_length_detector
// PURPOSE
//   Parametrised consecutive-bit run detector on a serial input w. Flags a run of
//   RUN0_LEN zeros or RUN1_LEN ones, in level or single-pulse mode. Samples only when
//   en=1. Uses a saturating run counter instead of one state per bit.
//   Sits behind serial receivers and test stimulus for line-idle and stuck-bit detection.
// PARAMETERS
//   CNT_W     8  width of run counter; run_len saturates at 2**CNT_W-1
//   RUN0_LEN  4  zeros needed to hit; legal range 1..2**CNT_W-1
//   RUN1_LEN  4  ones needed to hit; legal range 1..2**CNT_W-1
// PORTS
//   clk        in   1      clock; all logic on the rising edge
//   rst        in   1      asynchronous, active-high reset
//   en         in   1      sample strobe; w is consumed only when en=1
//   w          in   1      serial data bit
//   clr        in   1      synchronous clear to IDLE; priority over en
//   pulse_mode in   1      0 = level outputs, 1 = one-cycle pulse on hit entry
//   out        out  1      out0 | out1
//   out0       out  1      zero-run hit
//   out1       out  1      one-run hit
//   run_bit    out  1      value of the current run (0 in IDLE)
//   run_len    out  CNT_W  length of the current run, saturating (0 in IDLE)
//   state      out  5      one-hot state {HIT1,HIT0,RUN1,RUN0,IDLE}
// BEHAVIOUR
//   - Reset (rst=1, async): state=IDLE (5'b00001), run_len=0, run_bit=0, all out*=0.
//   - Every output is registered. Outputs reflect a sample from the edge after en=1.
//   - Priority per edge: rst > clr > en. clr=1 gives the reset values on the next edge.
//     This holds even if en=1.
//   - en=0: state, run_len and run_bit hold. Level outputs hold. Pulse outputs drop to 0.
//     An en gap does not break a run.
//   - Transitions on en=1 with sampled bit b:
//     * From IDLE: state=RUN<b>, run_len=1, run_bit=b.
//       If the target length is 1, state goes straight to HIT<b>.
//     * From RUNx or HITx with b==x: run_len=sat(run_len+1).
//       In RUNx, if run_len+1 == RUNx_LEN, state goes to HITx.
//       In HITx, state stays HITx.
//     * From RUNx or HITx with b!=x: run_len=1, run_bit=b.
//       State goes to RUN<b>, or to HIT<b> if that target length is 1.
//   - Level mode: out0 = (state==HIT0), out1 = (state==HIT1).
//   - Pulse mode: out<x>=1 only on the cycle following the edge that entered HITx.
//     Staying in HITx gives 0. Leaving and re-entering HITx gives a new pulse.
//   - pulse_mode is sampled every edge. Changing it mid-hit affects outputs from the next
//     edge only; state is unaffected.
//   - Saturation: run_len stops at 2**CNT_W-1 and never wraps. state stays HITx.
//   - The default parameters reproduce the legacy 4-zeros / 4-ones detector.
//     A run of 4 gives out=1 on the cycle after the 4th sample.
// TESTING
//   1. rst pulse, then en=1 with w=0,0,0,0 -> run_len 1,2,3,4; out0=1 and state=HIT0
//      after the 4th edge.
//   2. w=0,0,0,1 -> no hit; then run_len=1, run_bit=1, state=RUN1, out=0.
//   3. CNT_W=8, 300 ones, level mode -> out1=1 from the 4th edge on; run_len saturates
//      at 255 and stays there.
//   4. pulse_mode=1, w=1 x6, then 0, then 1 x4 -> out1 pulses exactly twice, one cycle
//      each: after the 4th and the 11th samples.
//   5. w=0,0 then en=0 for 5 cycles, then w=0,0 -> outputs hold during the gap; hit after
//      the 4th en sample.
//   6. Async rst mid-run (run_len=3) -> IDLE and zeros immediately.
//      clr=1 with en=1, w=0 at run_len=3 -> IDLE, run_len=0, no hit.

Source files
------------

// File: rtl/run_length_detector.sv
// run_length_detector
//   Serial consecutive-bit run detector. Tracks the value and length of the
//   current run of identical samples on w and flags when a zero-run reaches
//   RUN0_LEN or a one-run reaches RUN1_LEN. Level or single-pulse outputs.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no sample taken since reset/clear; run_len=0, run_bit=0
//   RUN0  | counting a run of zeros, still shorter than RUN0_LEN
//   RUN1  | counting a run of ones, still shorter than RUN1_LEN
//   HIT0  | zero-run has reached RUN0_LEN; stays here while zeros continue
//   HIT1  | one-run has reached RUN1_LEN; stays here while ones continue
module run_length_detector #(
  parameter int CNT_W    = 8,
  parameter int RUN0_LEN = 4,
  parameter int RUN1_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  input  logic             pulse_mode,
  output logic             out,
  output logic             out0,
  output logic             out1,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_len,
  output logic [4:0]       state
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    RUN0 = 5'b00010,
    RUN1 = 5'b00100,
    HIT0 = 5'b01000,
    HIT1 = 5'b10000
  } state_t;

  // Targets are compared against the incremented count, which is one bit
  // wider than the counter so saturation can be detected from the carry.
  localparam logic [CNT_W:0] LEN0 = (CNT_W+1)'(RUN0_LEN);
  localparam logic [CNT_W:0] LEN1 = (CNT_W+1)'(RUN1_LEN);
  localparam bit             INSTANT0 = (RUN0_LEN == 1);
  localparam bit             INSTANT1 = (RUN1_LEN == 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             bit_q, bit_d;
  logic             out0_q, out0_d;
  logic             out1_q, out1_d;
  logic             out_q, out_d;

  logic [CNT_W:0]   len_inc;
  logic [CNT_W-1:0] len_sat;
  logic             same_bit;
  logic             in_hit0, in_hit1;
  logic             hit0_d, hit1_d;

  // Incremented and saturated run length; the carry bit marks an overflow,
  // in which case the count simply stays at its all-ones maximum.
  always_comb begin
    len_inc = {1'b0, len_q} + {{CNT_W{1'b0}}, 1'b1};
    len_sat = len_inc[CNT_W] ? len_q : len_inc[CNT_W-1:0];
  end

  // First state of a fresh run of value b: straight to HIT when the target is 1.
  function automatic state_t fresh_run(input logic b);
    if (b) fresh_run = INSTANT1 ? HIT1 : RUN1;
    else   fresh_run = INSTANT0 ? HIT0 : RUN0;
  endfunction

  // State register and run tracking; async reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state, run length and run value.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bit_d    = bit_q;
    same_bit = (w == bit_q);
    if (clr) begin
      state_d = IDLE;
      len_d   = '0;
      bit_d   = 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          state_d = fresh_run(w);
          len_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          bit_d   = w;
        end
        RUN0, RUN1, HIT0, HIT1: begin
          if (same_bit) begin
            len_d = len_sat;
            if (state_q == RUN0 && len_inc == LEN0) state_d = HIT0;
            if (state_q == RUN1 && len_inc == LEN1) state_d = HIT1;
          end else begin
            state_d = fresh_run(w);
            len_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            bit_d   = w;
          end
        end
        default: begin
          state_d = IDLE;
          len_d   = '0;
          bit_d   = 1'b0;
        end
      endcase
    end
  end

  // Output decode: level follows the next state, pulse fires only on the
  // sampled edge that enters a HIT state from anywhere else.
  always_comb begin
    in_hit0 = (state_q == HIT0);
    in_hit1 = (state_q == HIT1);
    hit0_d  = (state_d == HIT0);
    hit1_d  = (state_d == HIT1);
    out0_d  = 1'b0;
    out1_d  = 1'b0;
    if (!clr) begin
      if (pulse_mode) begin
        out0_d = en && hit0_d && !in_hit0;
        out1_d = en && hit1_d && !in_hit1;
      end else begin
        out0_d = hit0_d;
        out1_d = hit1_d;
      end
    end
    out_d = out0_d | out1_d;
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_q <= 1'b0;
      out1_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      out0_q <= out0_d;
      out1_q <= out1_d;
      out_q  <= out_d;
    end
  end

  assign out     = out_q;
  assign out0    = out0_q;
  assign out1    = out1_q;
  assign run_bit = bit_q;
  assign run_len = len_q;
  assign state   = state_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Testbench for run_length_detector: directed sequences, a run-length model
// compared every cycle, and literal expectations at key points.
module tb_run_length_detector;

  localparam int CNT_W    = 8;
  localparam int RUN0_LEN = 4;
  localparam int RUN1_LEN = 4;
  localparam int MAXLEN   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             w = 1'b0;
  logic             clr = 1'b0;
  logic             pulse_mode = 1'b0;
  logic             out, out0, out1, run_bit;
  logic [CNT_W-1:0] run_len;
  logic [4:0]       state;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  run_length_detector #(.CNT_W(CNT_W), .RUN0_LEN(RUN0_LEN), .RUN1_LEN(RUN1_LEN)) dut (
    .clk(clk), .rst(rst), .en(en), .w(w), .clr(clr), .pulse_mode(pulse_mode),
    .out(out), .out0(out0), .out1(out1), .run_bit(run_bit), .run_len(run_len),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the run is just (active, value, unbounded length). Hits are
  // "length >= target"; a pulse is a hit now that was not a hit before.
  bit m_active, m_bit, m_out0, m_out1;
  int m_len;
  bit t_was0, t_was1, t_is0, t_is1, t_nb;
  int t_nl;

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_active <= 0; m_bit <= 0; m_len <= 0; m_out0 <= 0; m_out1 <= 0;
    end else if (en) begin
      t_was0 = m_active && !m_bit && m_len >= RUN0_LEN;
      t_was1 = m_active &&  m_bit && m_len >= RUN1_LEN;
      t_nb   = w;
      t_nl   = (m_active && m_bit == w) ? m_len + 1 : 1;
      t_is0  = !t_nb && t_nl >= RUN0_LEN;
      t_is1  =  t_nb && t_nl >= RUN1_LEN;
      m_active <= 1; m_bit <= t_nb; m_len <= t_nl;
      m_out0 <= pulse_mode ? (t_is0 && !t_was0) : t_is0;
      m_out1 <= pulse_mode ? (t_is1 && !t_was1) : t_is1;
    end else begin
      m_out0 <= pulse_mode ? 1'b0 : (m_active && !m_bit && m_len >= RUN0_LEN);
      m_out1 <= pulse_mode ? 1'b0 : (m_active &&  m_bit && m_len >= RUN1_LEN);
    end
  end

  function automatic int exp_state();
    bit hit;
    if (!m_active) return 5'b00001;
    hit = m_bit ? (m_len >= RUN1_LEN) : (m_len >= RUN0_LEN);
    if (hit) return m_bit ? 5'b10000 : 5'b01000;
    return m_bit ? 5'b00100 : 5'b00010;
  endfunction

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_state",   int'(state),   exp_state());
      chk("m_run_len", int'(run_len), (m_len > MAXLEN) ? MAXLEN : m_len);
      chk("m_run_bit", int'(run_bit), int'(m_bit));
      chk("m_out0",    int'(out0),    int'(m_out0));
      chk("m_out1",    int'(out1),    int'(m_out1));
      chk("m_out",     int'(out),     int'(m_out0 | m_out1));
    end
  end

  task automatic step(input logic e, input logic b, input logic c = 1'b0);
    en = e; w = b; clr = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 0; clr = 0;
    #3;
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  int pulses, first_p, second_p;

  initial begin
    do_reset();
    chk("rst_state", int'(state), 5'b00001);
    chk("rst_len", int'(run_len), 0);
    chk("rst_out", int'(out), 0);
    cmp_on = 1'b1;

    // 1: four zeros
    for (int i = 1; i <= 4; i++) begin
      step(1, 0);
      chk("t1_len", int'(run_len), i);
      chk("t1_out0", int'(out0), (i == 4) ? 1 : 0);
    end
    chk("t1_state", int'(state), 5'b01000);

    // 2: 0,0,0,1 after a clear
    step(0, 0, 1);
    chk("t2_clr_state", int'(state), 5'b00001);
    step(1, 0); step(1, 0); step(1, 0); step(1, 1);
    chk("t2_len", int'(run_len), 1);
    chk("t2_bit", int'(run_bit), 1);
    chk("t2_state", int'(state), 5'b00100);
    chk("t2_out", int'(out), 0);

    // 3: 300 ones in level mode (run already has one 1)
    for (int i = 2; i <= 300; i++) begin
      step(1, 1);
      if (i == 4) chk("t3_out1_at4", int'(out1), 1);
    end
    chk("t3_sat", int'(run_len), 255);
    chk("t3_out1", int'(out1), 1);
    chk("t3_state", int'(state), 5'b10000);

    // Switch to pulse mode mid-hit: no pulse while staying in HIT1
    pulse_mode = 1'b1;
    step(1, 1);
    chk("pm_switch_out1", int'(out1), 0);
    chk("pm_switch_state", int'(state), 5'b10000);
    pulse_mode = 1'b0;
    step(0, 1);
    chk("lvl_back_out1", int'(out1), 1);

    // 4: pulse mode, 1 x6, 0, 1 x4
    step(0, 0, 1);
    pulse_mode = 1'b1;
    pulses = 0; first_p = 0; second_p = 0;
    for (int i = 1; i <= 11; i++) begin
      step(1, (i == 7) ? 1'b0 : 1'b1);
      if (out1) begin
        pulses++;
        if (pulses == 1) first_p = i;
        if (pulses == 2) second_p = i;
      end
    end
    chk("t4_pulses", pulses, 2);
    chk("t4_first", first_p, 4);
    chk("t4_second", second_p, 11);
    pulse_mode = 1'b0;

    // 5: en gap does not break a run
    step(0, 0, 1);
    step(1, 0); step(1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1);
      chk("t5_hold_len", int'(run_len), 2);
    end
    step(1, 0);
    chk("t5_out0_3rd", int'(out0), 0);
    step(1, 0);
    chk("t5_out0_4th", int'(out0), 1);

    // 6a: async reset mid-run
    step(0, 0, 1);
    step(1, 0); step(1, 0); step(1, 0);
    chk("t6_len3", int'(run_len), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", int'(state), 5'b00001);
    chk("t6_rst_len", int'(run_len), 0);
    chk("t6_rst_out", int'(out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // 6b: clr beats en
    step(1, 0); step(1, 0); step(1, 0);
    step(1, 0, 1);
    chk("t6_clr_state", int'(state), 5'b00001);
    chk("t6_clr_len", int'(run_len), 0);
    chk("t6_clr_out0", int'(out0), 0);
    step(1, 0);
    chk("t6_after_clr_len", int'(run_len), 1);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
